// File: rtl/camera_exposure_seq_pkg.sv
// camera_seq_pkg: shared state encoding, readout timing constants and exposure clamp
package camera_seq_pkg;
  typedef enum logic [1:0] {S_IDLE, S_EXPOSE, S_READ} seq_state_t;
  localparam int READ_STEPS = 4;
  localparam int ADC_STEP = 1;
  function automatic int unsigned clamp(input int unsigned v, input int unsigned lo, input int unsigned hi);
    return v < lo ? lo : (v > hi ? hi : v);
  endfunction
endpackage

// File: rtl/camera_exposure_seq_if.sv
// camera_exposure_seq_if: control/pixel-array bus of the exposure sequencer; CAMERA_SEQ_CONTINUOUS_EN adds cont
interface camera_exposure_seq_if #(parameter int EXP_W = 5, parameter int ROWS = 2);
  logic             init;
  logic [EXP_W-1:0] EX_time;
`ifdef CAMERA_SEQ_CONTINUOUS_EN
  logic             cont;
`endif
  logic             Erase;
  logic             Expose;
  logic [ROWS-1:0]  NRE;
  logic             ADC;
  logic             ex_lock;
  logic             done;
`ifdef CAMERA_SEQ_CONTINUOUS_EN
  modport master (output init, EX_time, cont, input Erase, Expose, NRE, ADC, ex_lock, done);
  modport slave  (input init, EX_time, cont, output Erase, Expose, NRE, ADC, ex_lock, done);
`else
  modport master (output init, EX_time, input Erase, Expose, NRE, ADC, ex_lock, done);
  modport slave  (input init, EX_time, output Erase, Expose, NRE, ADC, ex_lock, done);
`endif
endinterface

// File: rtl/camera_exposure_seq_readout.sv
// readout_seq: row/step counter producing active-low row enables and one ADC strobe per row
module readout_seq
  import camera_seq_pkg::*;
#(
  parameter int ROWS = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [ROWS-1:0] NRE,
  output logic            ADC,
  output logic            last
);
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int SW = $clog2(READ_STEPS);
  logic          r_act;
  logic [RW-1:0] r_row;
  logic [SW-1:0] r_step;
  logic          w_row_end;
  assign w_row_end = r_step == SW'(READ_STEPS - 1);
  assign last      = r_act && w_row_end && r_row == RW'(ROWS - 1);
  assign ADC       = r_act && r_step == SW'(ADC_STEP);
  assign NRE       = ~((r_act && !w_row_end) ? ROWS'(1) << r_row : ROWS'(0));
  // walk rows 0..ROWS-1, READ_STEPS steps each; the final step of a row releases its enable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_act  <= 1'b0;
      r_row  <= '0;
      r_step <= '0;
    end else if (start) begin
      r_act  <= 1'b1;
      r_row  <= '0;
      r_step <= '0;
    end else if (r_act) begin
      r_step <= w_row_end ? '0 : r_step + SW'(1);
      if (w_row_end) begin
        r_row <= r_row + RW'(1);
        if (last) r_act <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/camera_exposure_seq.sv
// camera_exposure_seq: erase/expose/readout sequencer for the pixel array; CAMERA_SEQ_CONTINUOUS_EN enables back-to-back frames
module camera_exposure_seq
  import camera_seq_pkg::*;
#(
  parameter int unsigned EXP_W   = 5,
  parameter int unsigned EXP_MIN = 2,
  parameter int unsigned EXP_MAX = 30,
  parameter int unsigned ROWS    = 2
) (
  input logic                   clk,
  input logic                   reset,
  camera_exposure_seq_if.slave  bus
);
  seq_state_t       r_state;
  logic [EXP_W-1:0] r_cnt;
  logic [EXP_W-1:0] w_n;
  logic             w_start;
  logic             w_last;
  logic             w_cont;
  logic [ROWS-1:0]  w_nre;
  logic             w_adc;
  assign w_n     = EXP_W'(clamp(32'(bus.EX_time), EXP_MIN, EXP_MAX));
  assign w_start = r_state == S_EXPOSE && r_cnt == '0;
`ifdef CAMERA_SEQ_CONTINUOUS_EN
  assign w_cont  = bus.cont;
`else
  assign w_cont  = 1'b0;
`endif
  // sequencer: exposure length is latched on entry, later EX_time/init changes only matter in IDLE or the done cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.init) begin
          r_state <= S_EXPOSE;
          r_cnt   <= w_n - EXP_W'(1);
        end
        S_EXPOSE: begin
          r_state <= w_start ? S_READ : S_EXPOSE;
          r_cnt   <= w_start ? r_cnt : r_cnt - EXP_W'(1);
        end
        S_READ: if (w_last) begin
          r_state <= w_cont ? S_EXPOSE : S_IDLE;
          r_cnt   <= w_n - EXP_W'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  readout_seq #(.ROWS(ROWS)) u_readout (
    .clk   (clk),
    .reset (reset),
    .start (w_start),
    .NRE   (w_nre),
    .ADC   (w_adc),
    .last  (w_last)
  );
  assign bus.Erase   = r_state == S_IDLE;
  assign bus.Expose  = r_state == S_EXPOSE;
  assign bus.ex_lock = r_state != S_IDLE;
  assign bus.done    = r_state == S_READ && w_last;
  assign bus.NRE     = w_nre;
  assign bus.ADC     = w_adc;
endmodule
